// File: rtl/timer_pkg.sv
// Shared types for the timer reload control stage.
// State encoding and mode constants.
package timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } tstate_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_reload_ctrl_tc_detect.sv
// Terminal-count detector for the loadable up-counter.
// term is high when every bit of q is set.
module tc_detect #(
  parameter int N = 4
) (
  input  logic [N-1:0] q,
  output logic         term
);

  assign term = &q;

endmodule

// File: rtl/timer_reload_ctrl.sv
// Timer control stage driving a loadable up-counter (En/load/C).
// One-shot or periodic, with a registered expiry tick.
module timer_reload_ctrl
  import timer_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] period,
  input  logic [N-1:0] Q,
  output logic         En,
  output logic         load,
  output logic [N-1:0] C,
  output logic         tick,
  output logic         busy,
  output logic         done,
  output logic         err
);

  tstate_t      state;
  tstate_t      state_nxt;
  logic         mode_r;
  logic         term;
  logic         idle_like;
  logic         accept;
  logic         reject;
  logic         tick_nxt;
  logic [N-1:0] reload;

  tc_detect #(.N(N)) u_tc (
    .q    (Q),
    .term (term)
  );

  // Counter starts at 2^N - period so it hits all-ones after period cycles.
  assign reload = ~(period - {{(N-1){1'b0}}, 1'b1});

  always_comb begin
    state_nxt = state;
    idle_like = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    tick_nxt  = 1'b0;
    En        = 1'b0;
    load      = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        idle_like = 1'b1;
        done      = (state == S_DONE);
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (start) begin
          if (period != '0) begin
            accept    = 1'b1;
            state_nxt = S_LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      S_LOAD: begin
        load      = 1'b1;
        busy      = 1'b1;
        state_nxt = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        En       = 1'b1;
        busy     = 1'b1;
        load     = term & (mode_r == MODE_PERIODIC);
        tick_nxt = term & ~stop;
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (term && mode_r == MODE_ONESHOT) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      C      <= '0;
      mode_r <= MODE_ONESHOT;
      tick   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state <= state_nxt;
      tick  <= tick_nxt;
      err   <= idle_like & reject;
      if (accept) begin
        C      <= reload;
        mode_r <= mode;
      end
    end
  end

endmodule

// File: doc/timer_reload_ctrl.md
Name: timer_reload_ctrl

Overview:
- Control stage that sits directly upstream of the loadable N-bit up-counter and drives its En, load and C inputs.
- Monitors the counter's Q output and turns it into a programmable timer with a period of 1..2^N-1 cycles.
- Supports one-shot and auto-reload (periodic) modes, and emits a one-cycle tick each time a period expires.

Parameters:
N, 4, width of the counter, the period value and the reload value

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
start  input  1  request to begin timing; sampled in IDLE/DONE only
stop  input  1  abort; has priority over start and over terminal count
mode  input  1  0 = one-shot, 1 = periodic; latched on accepted start
period  input  N  period in cycles; latched on accepted start; 0 is illegal
Q  input  N  counter state, fed back from the counter
En  output  1  counter enable
load  output  1  counter parallel-load select
C  output  N  counter parallel-load value (registered reload value)
tick  output  1  one-cycle pulse, registered, marks period expiry
busy  output  1  high in LOAD and RUN
done  output  1  high while in DONE (one-shot finished)
err  output  1  one-cycle pulse on a start attempted with period == 0

Behaviour:
- States: IDLE, LOAD, RUN, DONE.
- Internal terminal signal: term = (Q == all ones).
- Reset (rst=1 at a clk edge, any state): state IDLE; C=0; mode_r=0; tick=0; err=0. Decoded outputs give En=0, load=0, busy=0, done=0.
- IDLE or DONE, stop=0, start=1:
  - period != 0: C <= ~(period-1), which equals 2^N - period mod 2^N; mode_r <= mode; next state LOAD.
  - period == 0: err=1 for one cycle; state unchanged; C unchanged.
- DONE with stop=1 -> IDLE.
- LOAD (one cycle): load=1, En=0; next state RUN. The counter holds C on the following edge.
- RUN: En=1.
  - term=1 and mode_r=1: load=1 in the same cycle (combinational from Q), so the counter reloads C on the next edge instead of wrapping. Exact period = period_r cycles.
  - term=1 and mode_r=0: load=0; the counter wraps to 0; next state DONE.
  - tick <= RUN & term & ~stop. Tick lags the Q=all-ones cycle by exactly one cycle.
- period=1: C = all ones, so term and load are high on every RUN cycle and tick is continuously high from the second RUN cycle.
- stop=1 in LOAD or RUN -> IDLE next edge, with En=0 from then on.
  - stop coinciding with term: no tick and no transition to DONE.
  - A load asserted in that same cycle is permitted; it is harmless.
- start during LOAD or RUN: ignored; no restart and no err.
- start and stop together in IDLE/DONE: stop wins; the block goes to or stays in IDLE.
- rst mid-operation: identical to reset; any pending tick is cleared.
- Output decode:
  - En = (RUN)
  - busy = (LOAD | RUN)
  - done = (DONE)
  - load = (LOAD) | (RUN & term & mode_r)
- All registered state updates happen only on rising clk. No latches.

Decomposition:
- Package timer_pkg:
  - typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} tstate_t
  - localparam MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1
- One natural sub-module, tc_detect #(N) (Q -> term), a reduction-AND comparator.
- The counter is not instantiated inside this block; the bench instantiates both and wires C/load/En/Q.

Test Plan:
1. N=4, rst, then start=1, period=3, mode=1 at cycle t0:
   - LOAD at t1 with C=4'b1101.
   - Q=13,14,15 at t2..t4.
   - tick at t5, t8, t11; busy held high; no DONE.
2. start, period=5, mode=0:
   - C=4'b1011; Q counts 11..15.
   - Exactly one tick; then Q=0, En=0, busy=0, done=1 held.
   - A new start from DONE re-enters LOAD.
3. start with period=0 in IDLE -> err=1 for one cycle; load, En and busy stay 0; state remains IDLE.
4. period=1, mode=1 -> C=4'hF; load=1 every RUN cycle; tick high every cycle from the second RUN cycle.
5. period=4 periodic, stop=1 in the cycle Q=15 -> no tick; En=0 and busy=0 the next cycle. Also: start+stop together in DONE -> IDLE.
6. rst=1 mid-RUN -> all outputs 0 at the next edge. Also: start pulsed during RUN -> ignored; tick spacing is unchanged.
